// File: rtl/bitfusion_pkg.sv
// -----------------------------------------------------------------------------
// bitfusion_pkg
// Shared types and helpers for the Bit Fusion systolic array.
//   mode_t    : precision mode of the packed 8-bit operands (1x8b, 2x4b, 4x2b)
//   state_t   : job controller states
//   OP_W      : packed operand width
//   ext8/4/2  : lane extension to an 18-bit signed working width, sign- or
//               zero-extended depending on the lane signedness flag
//   decode_mode : maps the raw 2-bit mode field onto mode_t (11 -> 8b)
// -----------------------------------------------------------------------------
package bitfusion_pkg;

    localparam int OP_W = 8;

    typedef enum logic [1:0] {
        MODE_8B = 2'b00,
        MODE_4B = 2'b01,
        MODE_2B = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_4B;
            2'b10:   return MODE_2B;
            default: return MODE_8B;
        endcase
    endfunction

    function automatic logic signed [17:0] ext8(input logic [7:0] v, input logic sgn);
        return {{10{sgn & v[7]}}, v};
    endfunction

    function automatic logic signed [17:0] ext4(input logic [3:0] v, input logic sgn);
        return {{14{sgn & v[3]}}, v};
    endfunction

    function automatic logic signed [17:0] ext2(input logic [1:0] v, input logic sgn);
        return {{16{sgn & v[1]}}, v};
    endfunction

endpackage

// File: rtl/bitfusion_array_pe.sv
// -----------------------------------------------------------------------------
// bf_pe
// One weight-stationary Bit Fusion processing element.
//   clk, nRST            : clock, asynchronous active-low reset
//   stall                : freezes the activation and psum registers
//   w_we, w_data         : weight write strobe and packed weight
//   mode, act_signed,
//   wgt_signed           : precision mode and lane signedness for the job
//   act_in  / act_out    : activation from the left / registered to the right
//   psum_in / psum_out   : partial sum from above / registered downwards
// psum_out = psum_in + dot(act_in, weight), wrapping modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module bf_pe
    import bitfusion_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             stall,
    input  logic             w_we,
    input  logic [OP_W-1:0]  w_data,
    input  mode_t            mode,
    input  logic             act_signed,
    input  logic             wgt_signed,
    input  logic [OP_W-1:0]  act_in,
    input  logic [ACC_W-1:0] psum_in,
    output logic [OP_W-1:0]  act_out,
    output logic [ACC_W-1:0] psum_out
);

    logic [OP_W-1:0]  wgt_q, wgt_d;
    logic [OP_W-1:0]  act_q, act_d;
    logic [ACC_W-1:0] psum_q, psum_d;

    // Lane products are at most 18 bits signed; the sum is sign-extended to
    // the accumulator width so negative dot products wrap correctly.
    function automatic logic [ACC_W-1:0] bf_dot(input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] w,
                                                input mode_t m,
                                                input logic as,
                                                input logic ws);
        logic signed [17:0] s;
        case (m)
            MODE_4B: s = ext4(a[7:4], as) * ext4(w[7:4], ws)
                       + ext4(a[3:0], as) * ext4(w[3:0], ws);
            MODE_2B: s = ext2(a[7:6], as) * ext2(w[7:6], ws)
                       + ext2(a[5:4], as) * ext2(w[5:4], ws)
                       + ext2(a[3:2], as) * ext2(w[3:2], ws)
                       + ext2(a[1:0], as) * ext2(w[1:0], ws);
            default: s = ext8(a, as) * ext8(w, ws);
        endcase
        return {{(ACC_W-18){s[17]}}, s};
    endfunction

    always_comb begin
        wgt_d  = w_we ? w_data : wgt_q;
        act_d  = act_q;
        psum_d = psum_q;
        if (!stall) begin
            act_d  = act_in;
            psum_d = psum_in + bf_dot(act_in, wgt_q, mode, act_signed, wgt_signed);
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wgt_q  <= '0;
            act_q  <= '0;
            psum_q <= '0;
        end else begin
            wgt_q  <= wgt_d;
            act_q  <= act_d;
            psum_q <= psum_d;
        end
    end

    assign act_out  = act_q;
    assign psum_out = psum_q;

endmodule

// File: rtl/bitfusion_array.sv
// -----------------------------------------------------------------------------
// bitfusion_array
// ROWS x COLS weight-stationary Bit Fusion systolic array with job controller.
//   clk, nRST                        : clock, asynchronous active-low reset
//   cfg_mode, cfg_act_signed,
//   cfg_wgt_signed, cfg_accumulate   : job configuration, latched on start
//   w_load_valid/row/col/data        : weight write port (IDLE only)
//   start, k_len, abort              : job control
//   act_valid/ready/data             : activation stream, row r in byte r
//   out_valid/ready/data/last        : result stream, column c in word c
//   busy, done                       : status and one-cycle completion pulse
// Row r activations are skewed by r cycles, bottom-row psums of column c are
// deskewed by COLS-1-c cycles, so a vector accepted at t appears at
// t+ROWS+COLS-1. A single token pipeline of the same depth tracks validity.
// -----------------------------------------------------------------------------
module bitfusion_array
    import bitfusion_pkg::*;
#(
    parameter  int ROWS   = 4,
    parameter  int COLS   = 4,
    parameter  int ACC_W  = 32,
    parameter  int KLEN_W = 16,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_act_signed,
    input  logic                  cfg_wgt_signed,
    input  logic                  cfg_accumulate,
    input  logic                  w_load_valid,
    input  logic [RW-1:0]         w_load_row,
    input  logic [CW-1:0]         w_load_col,
    input  logic [OP_W-1:0]       w_load_data,
    input  logic                  start,
    input  logic [KLEN_W-1:0]     k_len,
    input  logic                  abort,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [ROWS*OP_W-1:0]  act_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COLS*ACC_W-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PIPE = ROWS + COLS - 1;

    state_t            state_q, state_d;
    logic [KLEN_W-1:0] k_len_q, k_len_d;
    logic [KLEN_W-1:0] cnt_q, cnt_d;
    mode_t             mode_q, mode_d;
    logic              act_signed_q, act_signed_d;
    logic              wgt_signed_q, wgt_signed_d;
    logic              acc_mode_q, acc_mode_d;
    logic [PIPE-1:0]   tok_vld_q, tok_vld_d;
    logic [PIPE-1:0]   tok_last_q, tok_last_d;
    logic [ACC_W-1:0]  acc_q [COLS];
    logic [ACC_W-1:0]  acc_d [COLS];
    logic              acc_vld_q, acc_vld_d;
    logic              done_q, done_d;

    logic              stall, accept, last_accept, flush, w_we_any, job_start;
    logic [OP_W-1:0]   act_h  [ROWS][COLS+1];
    logic [ACC_W-1:0]  psum_v [ROWS+1][COLS];
    logic [ACC_W-1:0]  align  [COLS];
    logic [ROWS*OP_W-1:0] act_edge_unused;

    assign out_valid   = acc_mode_q ? acc_vld_q : tok_vld_q[PIPE-1];
    assign out_last    = acc_mode_q ? acc_vld_q : tok_last_q[PIPE-1];
    assign stall       = out_valid & ~out_ready;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign act_ready   = (state_q == RUN) && !stall && (cnt_q < k_len_q);
    assign accept      = act_valid && act_ready;
    assign last_accept = accept && (cnt_q == k_len_q - KLEN_W'(1));
    assign flush       = abort && (state_q != IDLE);
    assign w_we_any    = (state_q == IDLE) && w_load_valid;
    assign job_start   = (state_q == IDLE) && start && !abort;

    // ---- input skew: row r is delayed r cycles ----
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign act_h[0][0] = act_data[OP_W-1:0];
        end else begin : g_delay
            logic [OP_W-1:0] sk_q [r];
            logic [OP_W-1:0] sk_d [r];
            always_comb begin
                sk_d = sk_q;
                if (!stall) begin
                    sk_d[0] = act_data[r*OP_W +: OP_W];
                    for (int i = 1; i < r; i++) sk_d[i] = sk_q[i-1];
                end
            end
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    for (int i = 0; i < r; i++) sk_q[i] <= '0;
                end else begin
                    sk_q <= sk_d;
                end
            end
            assign act_h[r][0] = sk_q[r-1];
        end
        assign act_edge_unused[r*OP_W +: OP_W] = act_h[r][COLS];
    end

    // ---- PE grid ----
    for (genvar c = 0; c < COLS; c++) begin : g_top
        assign psum_v[0][c] = '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            bf_pe #(.ACC_W(ACC_W)) u_pe (
                .clk       (clk),
                .nRST      (nRST),
                .stall     (stall),
                .w_we      (w_we_any && (w_load_row == RW'(r)) && (w_load_col == CW'(c))),
                .w_data    (w_load_data),
                .mode      (mode_q),
                .act_signed(act_signed_q),
                .wgt_signed(wgt_signed_q),
                .act_in    (act_h[r][c]),
                .psum_in   (psum_v[r][c]),
                .act_out   (act_h[r][c+1]),
                .psum_out  (psum_v[r+1][c])
            );
        end
    end

    // ---- output deskew: column c is delayed COLS-1-c cycles ----
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign align[c] = psum_v[ROWS][c];
        end else begin : g_delay
            logic [ACC_W-1:0] ds_q [D];
            logic [ACC_W-1:0] ds_d [D];
            always_comb begin
                ds_d = ds_q;
                if (!stall) begin
                    ds_d[0] = psum_v[ROWS][c];
                    for (int i = 1; i < D; i++) ds_d[i] = ds_q[i-1];
                end
            end
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    for (int i = 0; i < D; i++) ds_q[i] <= '0;
                end else begin
                    ds_q <= ds_d;
                end
            end
            assign align[c] = ds_q[D-1];
        end
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < COLS; c++)
            out_data[c*ACC_W +: ACC_W] = acc_mode_q ? acc_q[c] : align[c];
    end

    // ---- job FSM ----
    always_comb begin
        state_d      = state_q;
        k_len_d      = k_len_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        act_signed_d = act_signed_q;
        wgt_signed_d = wgt_signed_q;
        acc_mode_d   = acc_mode_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    k_len_d      = k_len;
                    mode_d       = decode_mode(cfg_mode);
                    act_signed_d = cfg_act_signed;
                    wgt_signed_d = cfg_wgt_signed;
                    acc_mode_d   = cfg_accumulate;
                    cnt_d        = '0;
                    if (k_len == '0) done_d  = 1'b1;
                    else             state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d = cnt_q + KLEN_W'(1);
                    if (last_accept) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_valid && out_ready && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- token pipeline and column accumulators ----
    always_comb begin
        tok_vld_d  = tok_vld_q;
        tok_last_d = tok_last_q;
        acc_d      = acc_q;
        acc_vld_d  = acc_vld_q;
        if (flush) begin
            tok_vld_d  = '0;
            tok_last_d = '0;
            acc_vld_d  = 1'b0;
        end else begin
            if (job_start && (k_len != '0)) begin
                for (int c = 0; c < COLS; c++) acc_d[c] = '0;
            end
            if (acc_vld_q && out_ready) acc_vld_d = 1'b0;
            if (!stall) begin
                tok_vld_d  = (tok_vld_q  << 1) | PIPE'(accept);
                tok_last_d = (tok_last_q << 1) | PIPE'(last_accept);
                // In accumulate mode aligned vectors are summed instead of
                // emitted; the sum is presented one cycle after the last one.
                if (acc_mode_q && tok_vld_q[PIPE-1]) begin
                    for (int c = 0; c < COLS; c++) acc_d[c] = acc_q[c] + align[c];
                    if (tok_last_q[PIPE-1]) acc_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            k_len_q      <= '0;
            cnt_q        <= '0;
            mode_q       <= MODE_8B;
            act_signed_q <= 1'b0;
            wgt_signed_q <= 1'b0;
            acc_mode_q   <= 1'b0;
            tok_vld_q    <= '0;
            tok_last_q   <= '0;
            acc_vld_q    <= 1'b0;
            done_q       <= 1'b0;
            for (int c = 0; c < COLS; c++) acc_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            k_len_q      <= k_len_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            act_signed_q <= act_signed_d;
            wgt_signed_q <= wgt_signed_d;
            acc_mode_q   <= acc_mode_d;
            tok_vld_q    <= tok_vld_d;
            tok_last_q   <= tok_last_d;
            acc_vld_q    <= acc_vld_d;
            done_q       <= done_d;
            acc_q        <= acc_d;
        end
    end

endmodule

// File: tb/tb_bitfusion_array.sv
module tb_bitfusion_array;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int ACC_W  = 32;
    localparam int KLEN_W = 16;

    logic                  clk = 1'b0;
    logic                  nRST;
    logic [1:0]            cfg_mode;
    logic                  cfg_act_signed, cfg_wgt_signed, cfg_accumulate;
    logic                  w_load_valid;
    logic [1:0]            w_load_row, w_load_col;
    logic [7:0]            w_load_data;
    logic                  start;
    logic [KLEN_W-1:0]     k_len;
    logic                  abort;
    logic                  act_valid, act_ready;
    logic [ROWS*8-1:0]     act_data;
    logic                  out_valid, out_ready, out_last;
    logic [COLS*ACC_W-1:0] out_data;
    logic                  busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bitfusion_array #(.ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) dut (
        .clk(clk), .nRST(nRST),
        .cfg_mode(cfg_mode), .cfg_act_signed(cfg_act_signed),
        .cfg_wgt_signed(cfg_wgt_signed), .cfg_accumulate(cfg_accumulate),
        .w_load_valid(w_load_valid), .w_load_row(w_load_row),
        .w_load_col(w_load_col), .w_load_data(w_load_data),
        .start(start), .k_len(k_len), .abort(abort),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] col(input int c);
        return out_data[c*ACC_W +: ACC_W];
    endfunction

    // vector i: row r carries i*4+r+1, so with identity weights column c = i*4+c+1
    function automatic logic [31:0] vec(input int i);
        logic [31:0] v;
        for (int r = 0; r < ROWS; r++) v[r*8 +: 8] = 8'(i*4 + r + 1);
        return v;
    endfunction

    task automatic load_w(input int r, input int c, input logic [7:0] d);
        w_load_valid = 1'b1;
        w_load_row   = 2'(r);
        w_load_col   = 2'(c);
        w_load_data  = d;
        step();
        w_load_valid = 1'b0;
    endtask

    task automatic load_identity();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                load_w(r, c, (r == c) ? 8'd1 : 8'd0);
    endtask

    task automatic load_all(input logic [7:0] d);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                load_w(r, c, d);
    endtask

    task automatic start_job(input logic [1:0] m, input logic sa, input logic sw,
                             input logic acc, input int k);
        cfg_mode       = m;
        cfg_act_signed = sa;
        cfg_wgt_signed = sw;
        cfg_accumulate = acc;
        k_len          = KLEN_W'(k);
        start          = 1'b1;
        step();
        start          = 1'b0;
    endtask

    // count negedges from the accept until out_valid rises (bounded)
    task automatic wait_valid(input int first, input int max, output int n);
        n = first;
        while (!out_valid && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic run_single(input string pfx, input logic [1:0] m, input logic sa,
                              input logic sw, input logic [31:0] a,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        int n;
        start_job(m, sa, sw, 1'b0, 1);
        act_valid = 1'b1;
        act_data  = a;
        #1;
        chk({pfx, "_ready"}, act_ready, 1'b1);
        step();
        act_valid = 1'b0;
        wait_valid(1, 30, n);
        chk({pfx, "_latency"}, n, 7);
        chk({pfx, "_c0"}, col(0), e0);
        chk({pfx, "_c1"}, col(1), e1);
        chk({pfx, "_c2"}, col(2), e2);
        chk({pfx, "_c3"}, col(3), e3);
        chk({pfx, "_last"}, out_last, 1'b1);
        step();
        chk({pfx, "_done"}, done, 1'b1);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_vld_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int n, n_in, n_out, seen_vld, seen_done;
        logic saw_done, was_stalled;
        logic [COLS*ACC_W-1:0] prev;

        nRST = 1'b1;
        cfg_mode = 2'b00; cfg_act_signed = 1'b0; cfg_wgt_signed = 1'b0; cfg_accumulate = 1'b0;
        w_load_valid = 1'b0; w_load_row = '0; w_load_col = '0; w_load_data = '0;
        start = 1'b0; k_len = '0; abort = 1'b0;
        act_valid = 1'b0; act_data = '0; out_ready = 1'b1;
        #2 nRST = 1'b0;
        step(); step();
        chk("rst_act_ready", act_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", |out_data, 1'b0);
        nRST = 1'b1;
        step();

        // 8b signed identity
        load_identity();
        run_single("i8", 2'b00, 1'b1, 1'b1, 32'h01020304, 32'd4, 32'd3, 32'd2, 32'd1);

        // 4b unsigned: 4 * (3*2 + 5*1) = 44
        load_all(8'h21);
        run_single("u4", 2'b01, 1'b0, 1'b0, 32'h35353535, 32'd44, 32'd44, 32'd44, 32'd44);

        // 2b signed: lanes -1 * +1, 16 products -> -16 ; unsigned: 16 * 3 = 48
        load_all(8'h55);
        run_single("s2", 2'b10, 1'b1, 1'b1, 32'hFFFFFFFF,
                   32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0);
        run_single("u2", 2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd48, 32'd48, 32'd48, 32'd48);

        // mode 11 behaves as 8b: 0xFF unsigned * 0x55 per PE, 4 rows
        run_single("m11", 2'b11, 1'b0, 1'b0, 32'hFFFFFFFF,
                   32'd86700, 32'd86700, 32'd86700, 32'd86700);

        // k_len=8 with bubbles and a 5-cycle output stall
        load_identity();
        start_job(2'b00, 1'b1, 1'b1, 1'b0, 8);
        n_in = 0; n_out = 0; saw_done = 1'b0; was_stalled = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 80 && !saw_done; cyc++) begin
            if (done) begin
                saw_done = 1'b1;
            end else begin
                out_ready = !(cyc >= 9 && cyc < 14);
                act_valid = (n_in < 8) && (cyc % 2 == 0);
                act_data  = vec(n_in);
                #1;
                if (out_valid && !out_ready) begin
                    chk("stall_act_ready", act_ready, 1'b0);
                    if (was_stalled) begin
                        chk("stall_hold_lo", out_data[63:0], prev[63:0]);
                        chk("stall_hold_hi", out_data[127:64], prev[127:64]);
                    end
                    prev = out_data;
                    was_stalled = 1'b1;
                end else begin
                    was_stalled = 1'b0;
                end
                if (out_valid && out_ready) begin
                    for (int c = 0; c < COLS; c++)
                        chk($sformatf("stream_v%0d_c%0d", n_out, c), col(c), 32'(n_out*4 + c + 1));
                    chk($sformatf("stream_last%0d", n_out), out_last, (n_out == 7));
                    n_out++;
                end
                if (act_valid && act_ready) n_in++;
            end
            step();
        end
        act_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_n_in", n_in, 8);
        chk("stream_n_out", n_out, 8);
        chk("stream_done", saw_done, 1'b1);

        // accumulate k_len=3 with identity: each column 1+2+3
        start_job(2'b00, 1'b1, 1'b1, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            act_valid = 1'b1;
            act_data  = {4{8'(i + 1)}};
            #1;
            chk($sformatf("acc_ready%0d", i), act_ready, 1'b1);
            step();
        end
        act_valid = 1'b0;
        wait_valid(1, 30, n);
        chk("acc_latency", n, 8);
        for (int c = 0; c < COLS; c++) chk($sformatf("acc_c%0d", c), col(c), 32'd6);
        chk("acc_last", out_last, 1'b1);
        step();
        chk("acc_done", done, 1'b1);
        chk("acc_vld_drop", out_valid, 1'b0);
        step();
        chk("acc_single", out_valid, 1'b0);

        // k_len=0: done next cycle, no job
        start_job(2'b00, 1'b0, 1'b0, 1'b0, 0);
        chk("k0_done", done, 1'b1);
        chk("k0_busy", busy, 1'b0);
        step();
        chk("k0_done_pulse", done, 1'b0);
        chk("k0_no_out", out_valid, 1'b0);

        // abort together with start: abort wins
        abort = 1'b1;
        start_job(2'b00, 1'b1, 1'b1, 1'b0, 4);
        abort = 1'b0;
        chk("abort_start_busy", busy, 1'b0);

        // abort after two accepts
        start_job(2'b00, 1'b1, 1'b1, 1'b0, 5);
        act_valid = 1'b1; act_data = vec(0);
        step();
        act_data = vec(1);
        step();
        act_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        seen_vld = 0; seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen_vld++;
            if (done) seen_done++;
            step();
        end
        chk("abort_no_out", seen_vld, 0);
        chk("abort_no_done", seen_done, 0);
        run_single("post_abort", 2'b00, 1'b1, 1'b1, 32'h01020304, 32'd4, 32'd3, 32'd2, 32'd1);

        // reset during DRAIN clears outputs and weights
        start_job(2'b00, 1'b1, 1'b1, 1'b0, 1);
        act_valid = 1'b1; act_data = 32'h01020304;
        step();
        act_valid = 1'b0;
        step(); step();
        chk("drain_busy", busy, 1'b1);
        nRST = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_out_data", |out_data, 1'b0);
        chk("mrst_act_ready", act_ready, 1'b0);
        step();
        nRST = 1'b1;
        step();
        run_single("wclr", 2'b00, 1'b1, 1'b1, 32'h01020304, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
